secuenciador_kernel_5x5: RTL and testbench
==========================================

Name: secuenciador_kernel_5x5

Overview:
Controller that walks a 5x5 filter kernel line by line. For each line it requests the line from the line buffer. It then steps the byte-select code 0..3 across the mux bank, presenting each phase to the downstream MAC with a valid/ready handshake. It signals completion of the full kernel window and sits between the window/line-buffer logic and the mux/MAC datapath.

Parameters:
NUM_LINEAS, 5, kernel lines per window (1..8)
NUM_FASES, 4, byte-select phases per line (1..4; seleccion is 2 bits)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
inicio  input  1  start pulse; sampled only in REPOSO
cancelar  input  1  abort; highest priority, any state
pedir_linea  output  1  level request for line indice_linea, held until linea_lista
linea_lista  input  1  line buffer has presented requested line
indice_linea  output  3  current kernel line 0..NUM_LINEAS-1
seleccion  output  2  byte-select phase 0..NUM_FASES-1 to mux bank
configuracion  output  3  thermometer decode of seleccion: 0->000, 1->001, 2->011, 3->111
valido  output  1  phase data valid toward MAC
listo_destino  input  1  MAC accepts current phase
ultimo  output  1  current phase is last phase of last line
ocupado  output  1  high in any state other than REPOSO
fin  output  1  one-cycle pulse after final phase accepted

Behaviour:
- Reset (rst_n low, async): state REPOSO; indice_linea=0, fase=0; all outputs 0; configuracion=000.
- States: REPOSO, CARGA, BARRIDO, FIN. State, fase and indice are registered. Outputs are decoded from registered state/counters only, so they are glitch-free. configuracion is a combinational decode of the seleccion register.
- REPOSO: inicio=1 & cancelar=0 -> CARGA, indice=0, fase=0.
- CARGA: pedir_linea=1, valido=0.
  - linea_lista=1 -> BARRIDO next cycle with fase=0.
  - Otherwise remain in CARGA; there is no timeout.
- BARRIDO: valido=1, seleccion=fase. A transfer occurs on valido & listo_destino.
  - If no transfer occurs, seleccion, indice and valido hold stable.
  - On transfer with fase<NUM_FASES-1: fase+1.
  - On transfer with fase=last and indice<NUM_LINEAS-1: indice+1, fase=0, -> CARGA.
  - On transfer with fase=last and indice=last: -> FIN.
- ultimo = BARRIDO & fase=NUM_FASES-1 & indice=NUM_LINEAS-1.
- FIN: fin=1 for exactly one cycle; ocupado=1; -> REPOSO. inicio in FIN is ignored.
- inicio is ignored in CARGA, BARRIDO and FIN. There is no queuing.
- cancelar=1 in any state: next cycle REPOSO, counters 0, no fin pulse.
  - An in-flight phase is dropped. valido may fall without a transfer.
  - cancelar & inicio in the same cycle: stay in REPOSO.
- fase wraps only through the line-advance path. It never exceeds NUM_FASES-1, and indice never exceeds NUM_LINEAS-1.
- Latency with linea_lista and listo_destino tied high:
  - inicio at cycle 0 -> pedir_linea at cycle 1, first valido at cycle 2.
  - Per line: 1 CARGA cycle + NUM_FASES BARRIDO cycles.
  - fin at cycle 1 + NUM_LINEAS*(NUM_FASES+1) = cycle 26 for defaults.
- Reset asserted mid-operation: immediate return to reset values. No fin pulse.

Decomposition:
- Shared package: state encoding (REPOSO=2'd0, CARGA=2'd1, BARRIDO=2'd2, FIN=2'd3), defaults NUM_LINEAS=5 and NUM_FASES=4, and the thermometer constants.
- One sub-module: the existing byte-select decoder deco_seleccion_byte. Instantiate it as seleccion -> configuracion; do not duplicate the case table.
- FSM and counters stay in this module.

Test Plan:
- Reset then idle: rst_n low mid-BARRIDO (line 2, fase 1) -> all outputs 0 immediately. After release, inicio needed to restart; no fin.
- Full run, linea_lista and listo_destino tied high, inicio at cycle 0:
  - 20 transfers, seleccion sequence 0,1,2,3 per line, indice 0..4.
  - configuracion 000,001,011,111 per line.
  - ultimo only on transfer 20; fin at cycle 26 only.
- Backpressure: listo_destino low 3 cycles at line 1 fase 2 -> seleccion=2, configuracion=011, valido=1 held. Resumes at fase 2, no skipped or duplicated phase.
- Slow line buffer: linea_lista delayed 4 cycles for line 3 -> pedir_linea high 5 cycles with indice_linea=3, valido=0 throughout.
- Abort: cancelar at line 4 fase 1 -> REPOSO next cycle, ocupado=0, no fin. A following inicio restarts at indice 0, fase 0.
- Ignored start: inicio pulsed during BARRIDO and FIN -> no effect. Exactly one fin per accepted inicio.

Source files
------------

// File: rtl/secuenciador_kernel_5x5_pkg.sv
// Shared definitions for the 5x5 kernel sequencer: state encoding, default
// geometry and the thermometer codes driven onto the mux bank.
package secuenciador_kernel_5x5_pkg;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      CARGA   = 2'd1,
      BARRIDO = 2'd2,
      FIN     = 2'd3
   } estado_t;

   localparam int NUM_LINEAS_DEF = 5;
   localparam int NUM_FASES_DEF  = 4;

   localparam logic [2:0] CONF_SEL0 = 3'b000;
   localparam logic [2:0] CONF_SEL1 = 3'b001;
   localparam logic [2:0] CONF_SEL2 = 3'b011;
   localparam logic [2:0] CONF_SEL3 = 3'b111;

endpackage

// File: rtl/secuenciador_kernel_5x5_deco_seleccion_byte.sv
// Byte-select decoder: turns the 2-bit phase code into the thermometer
// configuration word consumed by the mux bank.
module deco_seleccion_byte
   import secuenciador_kernel_5x5_pkg::*;
(
   input  logic [1:0] seleccion,
   output logic [2:0] configuracion
);

   always_comb begin
      configuracion = CONF_SEL0;
      case (seleccion)
         2'd0:    configuracion = CONF_SEL0;
         2'd1:    configuracion = CONF_SEL1;
         2'd2:    configuracion = CONF_SEL2;
         default: configuracion = CONF_SEL3;
      endcase
   end

endmodule

// File: rtl/secuenciador_kernel_5x5.sv
// Kernel-window sequencer: requests each kernel line, then steps the byte-select
// phases toward the MAC with a valid/ready handshake and pulses fin at the end.
module secuenciador_kernel_5x5
   import secuenciador_kernel_5x5_pkg::*;
#(
   parameter int NUM_LINEAS = NUM_LINEAS_DEF,
   parameter int NUM_FASES  = NUM_FASES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inicio,
   input  logic       cancelar,
   output logic       pedir_linea,
   input  logic       linea_lista,
   output logic [2:0] indice_linea,
   output logic [1:0] seleccion,
   output logic [2:0] configuracion,
   output logic       valido,
   input  logic       listo_destino,
   output logic       ultimo,
   output logic       ocupado,
   output logic       fin
);

   localparam logic [2:0] ULTIMA_LINEA = 3'(NUM_LINEAS - 1);
   localparam logic [1:0] ULTIMA_FASE  = 2'(NUM_FASES - 1);

   estado_t    estado_q, estado_d;
   logic [1:0] fase_q, fase_d;
   logic [2:0] indice_q, indice_d;
   logic       transferencia;

   assign transferencia = (estado_q == BARRIDO) && listo_destino;

   // cancelar overrides every state; counters are cleared whenever we leave the window
   always_comb begin
      estado_d = estado_q;
      fase_d   = fase_q;
      indice_d = indice_q;
      if (cancelar) begin
         estado_d = REPOSO;
         fase_d   = 2'd0;
         indice_d = 3'd0;
      end else begin
         case (estado_q)
            REPOSO: begin
               if (inicio) begin
                  estado_d = CARGA;
                  fase_d   = 2'd0;
                  indice_d = 3'd0;
               end
            end
            CARGA: begin
               if (linea_lista) begin
                  estado_d = BARRIDO;
                  fase_d   = 2'd0;
               end
            end
            BARRIDO: begin
               if (transferencia) begin
                  if (fase_q != ULTIMA_FASE) begin
                     fase_d = fase_q + 2'd1;
                  end else if (indice_q != ULTIMA_LINEA) begin
                     estado_d = CARGA;
                     fase_d   = 2'd0;
                     indice_d = indice_q + 3'd1;
                  end else begin
                     estado_d = FIN;
                     fase_d   = 2'd0;
                     indice_d = 3'd0;
                  end
               end
            end
            FIN: begin
               estado_d = REPOSO;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= REPOSO;
         fase_q   <= 2'd0;
         indice_q <= 3'd0;
      end else begin
         estado_q <= estado_d;
         fase_q   <= fase_d;
         indice_q <= indice_d;
      end
   end

   // All handshake outputs come straight from registered state, never from inputs
   assign pedir_linea  = (estado_q == CARGA);
   assign valido       = (estado_q == BARRIDO);
   assign ocupado      = (estado_q != REPOSO);
   assign fin          = (estado_q == FIN);
   assign ultimo       = (estado_q == BARRIDO) && (fase_q == ULTIMA_FASE) &&
                         (indice_q == ULTIMA_LINEA);
   assign seleccion    = fase_q;
   assign indice_linea = indice_q;

   deco_seleccion_byte u_deco (
      .seleccion     (seleccion),
      .configuracion (configuracion)
   );

endmodule

// File: tb/tb_secuenciador_kernel_5x5.sv
// Self-checking bench for secuenciador_kernel_5x5: a scoreboard queue holds the
// expected phase stream of each accepted window and is drained on every transfer.
module tb_secuenciador_kernel_5x5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inicio;
   logic       cancelar;
   logic       linea_lista;
   logic       listo_destino;
   logic       pedir_linea;
   logic [2:0] indice_linea;
   logic [1:0] seleccion;
   logic [2:0] configuracion;
   logic       valido;
   logic       ultimo;
   logic       ocupado;
   logic       fin;

   typedef struct packed {
      logic [1:0] sel;
      logic [2:0] conf;
      logic [2:0] idx;
      logic       ult;
   } esperado_t;

   esperado_t sb[$];
   int        passed = 0;
   int        total  = 0;

   secuenciador_kernel_5x5 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .inicio        (inicio),
      .cancelar      (cancelar),
      .pedir_linea   (pedir_linea),
      .linea_lista   (linea_lista),
      .indice_linea  (indice_linea),
      .seleccion     (seleccion),
      .configuracion (configuracion),
      .valido        (valido),
      .listo_destino (listo_destino),
      .ultimo        (ultimo),
      .ocupado       (ocupado),
      .fin           (fin)
   );

   always #5 clk = ~clk;

   // Thermometer model: s ones in the low bits
   function automatic logic [2:0] termo(int s);
      return 3'((1 << s) - 1);
   endfunction

   // Expected phase stream for one complete 5x5 window
   task automatic push_window();
      esperado_t e;
      for (int l = 0; l < 5; l++) begin
         for (int f = 0; f < 4; f++) begin
            e.sel  = 2'(f);
            e.conf = termo(f);
            e.idx  = 3'(l);
            e.ult  = (l == 4 && f == 3);
            sb.push_back(e);
         end
      end
   endtask

   // Power-on reset values, then an asynchronous reset in the middle of line 2
   task automatic test_reset();
      int busy;
      rst_n = 1'b1; inicio = 1'b0; cancelar = 1'b0;
      linea_lista = 1'b1; listo_destino = 1'b1;
      #2 rst_n = 1'b0;
      #3;
      total++;
      if ({pedir_linea, indice_linea, seleccion, configuracion, valido, ultimo, ocupado, fin} !== 14'd0)
         $display("[TB] FAIL reset_initial: outputs=%b required=0", {pedir_linea, indice_linea, seleccion, configuracion, valido, ultimo, ocupado, fin});
      else passed++;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); inicio = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk); inicio = 1'b0;
      end
      total++;
      if ({valido, indice_linea, seleccion} !== {1'b1, 3'd2, 2'd1})
         $display("[TB] FAIL reset_checkpoint: valido/indice/sel=%b/%0d/%0d required 1/2/1", valido, indice_linea, seleccion);
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({pedir_linea, indice_linea, seleccion, configuracion, valido, ultimo, ocupado, fin} !== 14'd0)
         $display("[TB] FAIL reset_midrun: outputs=%b required=0", {pedir_linea, indice_linea, seleccion, configuracion, valido, ultimo, ocupado, fin});
      else passed++;
      @(negedge clk); rst_n = 1'b1;
      busy = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ocupado || fin) busy++;
      end
      total++;
      if (busy !== 0) $display("[TB] FAIL reset_idle: busy_cycles=%0d required 0", busy);
      else passed++;
   endtask

   // Free-running window with both handshakes tied high
   task automatic test_full_run();
      int xfers, fins;
      esperado_t e;
      xfers = 0; fins = 0;
      sb.delete(); push_window();
      linea_lista = 1'b1; listo_destino = 1'b1;
      @(negedge clk); inicio = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk); inicio = 1'b0;
         if (c == 1) begin
            total++;
            if ({pedir_linea, valido, ocupado} !== 3'b101)
               $display("[TB] FAIL full_cycle1: pedir/valido/ocupado=%b required 101", {pedir_linea, valido, ocupado});
            else passed++;
         end
         if (c == 2) begin
            total++;
            if ({pedir_linea, valido} !== 2'b01)
               $display("[TB] FAIL full_cycle2: pedir/valido=%b required 01", {pedir_linea, valido});
            else passed++;
         end
         if (fin) begin
            fins++;
            total++;
            if (c !== 26) $display("[TB] FAIL full_fin_cycle: fin at %0d required 26", c);
            else passed++;
         end
         if (valido && listo_destino) begin
            xfers++;
            total++;
            if (sb.size() == 0) $display("[TB] FAIL full_extra_transfer: cycle %0d", c);
            else begin
               e = sb.pop_front();
               if ({seleccion, configuracion, indice_linea, ultimo} !== e)
                  $display("[TB] FAIL full_phase: sel/conf/idx/ult=%0d/%b/%0d/%b required %0d/%b/%0d/%b",
                           seleccion, configuracion, indice_linea, ultimo, e.sel, e.conf, e.idx, e.ult);
               else passed++;
            end
         end else begin
            total++;
            if (ultimo !== 1'b0) $display("[TB] FAIL full_ultimo_idle: ultimo=%b required 0 at cycle %0d", ultimo, c);
            else passed++;
         end
      end
      total++;
      if ({xfers, fins, sb.size()} !== {32'd20, 32'd1, 32'd0})
         $display("[TB] FAIL full_totals: xfers/fins/left=%0d/%0d/%0d required 20/1/0", xfers, fins, sb.size());
      else passed++;
   endtask

   // MAC stalls three cycles on line 1 phase 2
   task automatic test_backpressure();
      int stall, fins, fin_c;
      esperado_t e;
      stall = 0; fins = 0; fin_c = 0;
      sb.delete(); push_window();
      linea_lista = 1'b1; listo_destino = 1'b1;
      @(negedge clk); inicio = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk); inicio = 1'b0;
         if (valido && indice_linea == 3'd1 && seleccion == 2'd2 && stall < 3) begin
            if (stall > 0) begin
               total++;
               if (configuracion !== 3'b011)
                  $display("[TB] FAIL bp_hold_conf: conf=%b required 011", configuracion);
               else passed++;
            end
            listo_destino = 1'b0;
            stall++;
         end else listo_destino = 1'b1;
         if (fin) begin fins++; fin_c = c; end
         if (valido && listo_destino) begin
            total++;
            if (sb.size() == 0) $display("[TB] FAIL bp_extra_transfer: cycle %0d", c);
            else begin
               e = sb.pop_front();
               if ({seleccion, configuracion, indice_linea, ultimo} !== e)
                  $display("[TB] FAIL bp_phase: sel/conf/idx/ult=%0d/%b/%0d/%b required %0d/%b/%0d/%b",
                           seleccion, configuracion, indice_linea, ultimo, e.sel, e.conf, e.idx, e.ult);
               else passed++;
            end
         end
      end
      listo_destino = 1'b1;
      total++;
      if ({stall, fins, fin_c, sb.size()} !== {32'd3, 32'd1, 32'd29, 32'd0})
         $display("[TB] FAIL bp_totals: stall/fins/fin_cycle/left=%0d/%0d/%0d/%0d required 3/1/29/0", stall, fins, fin_c, sb.size());
      else passed++;
   endtask

   // Line buffer answers line 3 only on its fifth request cycle
   task automatic test_slow_line();
      int req, fins, fin_c;
      esperado_t e;
      req = 0; fins = 0; fin_c = 0;
      sb.delete(); push_window();
      linea_lista = 1'b1; listo_destino = 1'b1;
      @(negedge clk); inicio = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk); inicio = 1'b0;
         if (pedir_linea && indice_linea == 3'd3) begin
            req++;
            total++;
            if (valido !== 1'b0) $display("[TB] FAIL slow_valido: valido=%b required 0 while loading", valido);
            else passed++;
            linea_lista = (req >= 5);
         end else linea_lista = 1'b1;
         if (fin) begin fins++; fin_c = c; end
         if (valido && listo_destino) begin
            total++;
            if (sb.size() == 0) $display("[TB] FAIL slow_extra_transfer: cycle %0d", c);
            else begin
               e = sb.pop_front();
               if ({seleccion, configuracion, indice_linea, ultimo} !== e)
                  $display("[TB] FAIL slow_phase: sel/conf/idx/ult=%0d/%b/%0d/%b required %0d/%b/%0d/%b",
                           seleccion, configuracion, indice_linea, ultimo, e.sel, e.conf, e.idx, e.ult);
               else passed++;
            end
         end
      end
      linea_lista = 1'b1;
      total++;
      if ({req, fins, fin_c, sb.size()} !== {32'd5, 32'd1, 32'd30, 32'd0})
         $display("[TB] FAIL slow_totals: req/fins/fin_cycle/left=%0d/%0d/%0d/%0d required 5/1/30/0", req, fins, fin_c, sb.size());
      else passed++;
   endtask

   // Abort while line 4 phase 1 is being offered
   task automatic test_abort();
      int xfers, fins;
      bit aborted, just;
      esperado_t e;
      xfers = 0; fins = 0; aborted = 0; just = 0;
      sb.delete(); push_window();
      linea_lista = 1'b1; listo_destino = 1'b1;
      @(negedge clk); inicio = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk); inicio = 1'b0; cancelar = 1'b0;
         if (just) begin
            just = 0;
            total++;
            if ({ocupado, valido, pedir_linea, indice_linea, seleccion, fin} !== 9'd0)
               $display("[TB] FAIL abort_state: ocu/val/ped/idx/sel/fin=%b required 0",
                        {ocupado, valido, pedir_linea, indice_linea, seleccion, fin});
            else passed++;
         end
         if (!aborted && valido && indice_linea == 3'd4 && seleccion == 2'd1) begin
            cancelar = 1'b1; aborted = 1; just = 1;
         end
         if (fin) fins++;
         if (valido && listo_destino && !cancelar) begin
            xfers++;
            total++;
            if (sb.size() == 0) $display("[TB] FAIL abort_extra_transfer: cycle %0d", c);
            else begin
               e = sb.pop_front();
               if ({seleccion, configuracion, indice_linea, ultimo} !== e)
                  $display("[TB] FAIL abort_phase: sel/conf/idx/ult=%0d/%b/%0d/%b required %0d/%b/%0d/%b",
                           seleccion, configuracion, indice_linea, ultimo, e.sel, e.conf, e.idx, e.ult);
               else passed++;
            end
         end
      end
      cancelar = 1'b0;
      total++;
      if ({aborted, xfers, fins, sb.size()} !== {1'b1, 32'd17, 32'd0, 32'd3})
         $display("[TB] FAIL abort_totals: aborted/xfers/fins/left=%0d/%0d/%0d/%0d required 1/17/0/3", aborted, xfers, fins, sb.size());
      else passed++;
      sb.delete();
   endtask

   // Restart after abort, with inicio pulses that must be ignored mid-run and in FIN
   task automatic test_ignored_start();
      int xfers, fins, fin_c;
      esperado_t e;
      xfers = 0; fins = 0; fin_c = 0;
      linea_lista = 1'b1; listo_destino = 1'b1;
      @(negedge clk); inicio = 1'b1; cancelar = 1'b1;
      @(negedge clk); inicio = 1'b0; cancelar = 1'b0;
      total++;
      if (ocupado !== 1'b0) $display("[TB] FAIL start_and_cancel: ocupado=%b required 0", ocupado);
      else passed++;
      sb.delete(); push_window();
      inicio = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         inicio = (c == 3 || c == 10 || c == 26);
         if (c == 27 || c == 28) begin
            total++;
            if (ocupado !== 1'b0) $display("[TB] FAIL ignored_fin_start: ocupado=%b required 0 at cycle %0d", ocupado, c);
            else passed++;
         end
         if (fin) begin fins++; fin_c = c; end
         if (valido && listo_destino) begin
            xfers++;
            total++;
            if (sb.size() == 0) $display("[TB] FAIL ignored_extra_transfer: cycle %0d", c);
            else begin
               e = sb.pop_front();
               if ({seleccion, configuracion, indice_linea, ultimo} !== e)
                  $display("[TB] FAIL ignored_phase: sel/conf/idx/ult=%0d/%b/%0d/%b required %0d/%b/%0d/%b",
                           seleccion, configuracion, indice_linea, ultimo, e.sel, e.conf, e.idx, e.ult);
               else passed++;
            end
         end
      end
      inicio = 1'b0;
      total++;
      if ({xfers, fins, fin_c, sb.size()} !== {32'd20, 32'd1, 32'd26, 32'd0})
         $display("[TB] FAIL ignored_totals: xfers/fins/fin_cycle/left=%0d/%0d/%0d/%0d required 20/1/26/0", xfers, fins, fin_c, sb.size());
      else passed++;
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_full_run();
      test_backpressure();
      test_slow_line();
      test_abort();
      test_ignored_start();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
